// File: rtl/hub_linear_fold_ctrl.sv
// hub_linear_fold_ctrl
// Sequencer for the folded hybrid-unary linear layer. It pulses the weight
// buffer load, then walks FOLD passes of 2**RWID bitstream cycles each. It
// clears the accumulator at the start of every pass and flips the
// double-buffer select once per frame. After waiting LAT cycles for the
// adder tree and activation to settle, it pulses done.
//
// Optional feature macro: HUB_FOLD_CTRL_PERF_EN (adds the perf_cnt port/counter)
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   frame request, honoured only in IDLE
//   busy     out  high from LOAD through DONE
//   load     out  one-cycle weight-buffer load pulse
//   part     out  [PWID] active fold index
//   clear    out  accumulator clear on the first cycle of each pass
//   sel      out  double-buffer select, toggles once per frame
//   done     out  one-cycle pulse, layer output valid
//   perf_cnt out  [32] frame cycle count (HUB_FOLD_CTRL_PERF_EN only)
module hub_linear_fold_ctrl #(
  parameter int FOLD = 2,
  parameter int RWID = 10,
  parameter int LAT  = 4,
  parameter int PWID = (FOLD > 1) ? $clog2(FOLD) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            load,
  output logic [PWID-1:0] part,
  output logic            clear,
  output logic            sel,
  output logic            done
`ifdef HUB_FOLD_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_cnt
`endif
);

  localparam int DWID = (LAT > 0) ? $clog2(LAT + 1) : 1;

  localparam logic [RWID:0]   CNT_LAST   = {1'b0, {RWID{1'b1}}};
  localparam logic [PWID-1:0] PART_LAST  = PWID'(FOLD - 1);
  localparam logic [DWID-1:0] DRAIN_LAST = (LAT > 0) ? DWID'(LAT - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t          state, state_n;
  logic [RWID:0]   cnt, cnt_n;
  logic [PWID-1:0] part_n;
  logic [DWID-1:0] drain, drain_n;
  logic            sel_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    part_n  = part;
    drain_n = drain;
    sel_n   = sel;
    unique case (state)
      IDLE: begin
        cnt_n  = '0;
        part_n = '0;
        if (start) state_n = LOAD;
      end
      LOAD: begin
        cnt_n   = '0;
        part_n  = '0;
        state_n = RUN;
      end
      RUN: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (part == PART_LAST) begin
            sel_n   = ~sel;
            drain_n = '0;
            state_n = (LAT == 0) ? DONE : DRAIN;
          end else begin
            part_n = part + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (drain == DRAIN_LAST) state_n = DONE;
        else                     drain_n = drain + 1'b1;
      end
      DONE: begin
        part_n  = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so each one lines up
  // with the state it describes; part and clear change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      part  <= '0;
      drain <= '0;
      sel   <= 1'b0;
      busy  <= 1'b0;
      load  <= 1'b0;
      clear <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      part  <= part_n;
      drain <= drain_n;
      sel   <= sel_n;
      busy  <= (state_n != IDLE);
      load  <= (state_n == LOAD);
      clear <= (state_n == RUN) && (cnt_n == '0);
      done  <= (state_n == DONE);
    end
  end

`ifdef HUB_FOLD_CTRL_PERF_EN
  // Reads 0 on LOAD, and counts the busy cycles before it. It holds the
  // frame length from DONE until the next LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt <= '0;
    end else if (state_n == LOAD) begin
      perf_cnt <= '0;
    end else if ((state != IDLE) && (state_n != IDLE)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hub_linear_fold_ctrl.sv
// Testbench for hub_linear_fold_ctrl. Two instances share stimulus:
// dut0 (FOLD=2, RWID=4, LAT=3) and dut1 (FOLD=1, RWID=3, LAT=0).
module tb_hub_linear_fold_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start;

  logic       busy0, load0, clear0, sel0, done0;
  logic [0:0] part0;
  logic       busy1, load1, clear1, sel1, done1;
  logic [0:0] part1;
`ifdef HUB_FOLD_CTRL_PERF_EN
  logic [31:0] perf0, perf1;
`endif

  hub_linear_fold_ctrl #(.FOLD(2), .RWID(4), .LAT(3)) u_dut0 (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy0), .load(load0), .part(part0), .clear(clear0),
    .sel(sel0), .done(done0)
`ifdef HUB_FOLD_CTRL_PERF_EN
    , .perf_cnt(perf0)
`endif
  );

  hub_linear_fold_ctrl #(.FOLD(1), .RWID(3), .LAT(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy1), .load(load1), .part(part1), .clear(clear1),
    .sel(sel1), .done(done1)
`ifdef HUB_FOLD_CTRL_PERF_EN
    , .perf_cnt(perf1)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int base   = 0;
  bit chk_en = 1'b0;

  // Model configuration and per-instance frame bookkeeping.
  int fold_a[2] = '{2, 1};
  int pass_a[2] = '{16, 8};
  int lat_a[2]  = '{3, 0};
  bit active[2] = '{0, 0};
  int n0[2]     = '{0, 0};
  int selm[2]   = '{0, 0};
  int perfh[2]  = '{0, 0};

  task automatic chk(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, d, cyc - base, act, exp);
    end
  endtask

  // Frame timeline relative to the cycle n0 where start was accepted:
  // t=1 LOAD, t=2..1+F*P RUN, then LAT drain cycles, done at t=2+F*P+LAT.
  task automatic model_cycle(input int d, input int a_busy, input int a_load,
                             input int a_part, input int a_clear, input int a_sel,
                             input int a_done, input int a_perf);
    int t, fp, dt;
    int e_busy, e_load, e_part, e_clear, e_done, e_perf;
    fp = fold_a[d] * pass_a[d];
    dt = 2 + fp + lat_a[d];
    t  = cyc - n0[d];
    e_busy = 0; e_load = 0; e_part = 0; e_clear = 0; e_done = 0;
    e_perf = perfh[d];
    if (active[d]) begin
      e_busy = 1;
      e_load = (t == 1) ? 1 : 0;
      e_done = (t == dt) ? 1 : 0;
      e_perf = t - 1;
      if (t >= 2 && t <= 1 + fp) begin
        e_part  = (t - 2) / pass_a[d];
        e_clear = ((t - 2) % pass_a[d] == 0) ? 1 : 0;
      end else if (t > 1 + fp) begin
        e_part = fold_a[d] - 1;
      end
    end
    chk("busy", d, a_busy, e_busy);
    chk("load", d, a_load, e_load);
    chk("part", d, a_part, e_part);
    chk("clear", d, a_clear, e_clear);
    chk("sel", d, a_sel, selm[d]);
    chk("done", d, a_done, e_done);
`ifdef HUB_FOLD_CTRL_PERF_EN
    chk("perf_cnt", d, a_perf, e_perf);
`else
    if (a_perf != 0) chk("perf_unused", d, a_perf, 0);
`endif
    if (rst) begin
      active[d] = 1'b0;
      selm[d]   = 0;
      perfh[d]  = 0;
    end else if (active[d]) begin
      if (t == 1 + fp) selm[d] = selm[d] ^ 1;
      if (t == dt) begin
        active[d] = 1'b0;
        perfh[d]  = dt - 1;
      end
    end else if (start) begin
      active[d] = 1'b1;
      n0[d]     = cyc;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
`ifdef HUB_FOLD_CTRL_PERF_EN
      model_cycle(0, int'(busy0), int'(load0), int'(part0), int'(clear0), int'(sel0), int'(done0), int'(perf0));
      model_cycle(1, int'(busy1), int'(load1), int'(part1), int'(clear1), int'(sel1), int'(done1), int'(perf1));
`else
      model_cycle(0, int'(busy0), int'(load0), int'(part0), int'(clear0), int'(sel0), int'(done0), 0);
      model_cycle(1, int'(busy1), int'(load1), int'(part1), int'(clear1), int'(sel1), int'(done1), 0);
`endif
    end
  end

  task automatic go_to(input int c);
    while (cyc < base + c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    base = cyc;
  endtask

  initial begin
    int dn;
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Single frame with stray start pulses at 5 and 20.
    do_reset();
    dn = 0;
    for (int c = 0; c < 45; c++) begin
      go_to(c);
      if (c == 0)  chk("reset_busy", 0, int'(busy0), 0);
      if (c == 1)  chk("lit_load1", 0, int'(load0), 1);
      if (c == 2)  chk("lit_load2", 0, int'(load0), 0);
      if (c == 17) chk("lit_part17", 0, int'(part0), 0);
      if (c == 18) chk("lit_part18", 0, int'(part0), 1);
      if (c == 18) chk("lit_clear18", 0, int'(clear0), 1);
      if (c == 19) chk("lit_clear19", 0, int'(clear0), 0);
      if (c == 33) chk("lit_sel33", 0, int'(sel0), 0);
      if (c == 34) chk("lit_sel34", 0, int'(sel0), 1);
      if (c == 37) chk("lit_done37", 0, int'(done0), 1);
      if (c == 37) chk("lit_busy37", 0, int'(busy0), 1);
      if (c == 38) chk("lit_busy38", 0, int'(busy0), 0);
      if (c == 9)  chk("lit_f1_sel9", 1, int'(sel1), 0);
      if (c == 10) chk("lit_f1_done10", 1, int'(done1), 1);
      if (c == 10) chk("lit_f1_sel10", 1, int'(sel1), 1);
`ifdef HUB_FOLD_CTRL_PERF_EN
      if (c == 37) chk("lit_perf37", 0, int'(perf0), 36);
      if (c == 44) chk("lit_perf44", 0, int'(perf0), 36);
`endif
      dn += int'(done0);
      start = (c == 0 || c == 5 || c == 20);
    end
    chk("done_count", 0, dn, 1);

    // Reset mid-RUN, then restart.
    do_reset();
    for (int c = 0; c < 60; c++) begin
      go_to(c);
      if (c == 11) chk("rst_busy", 0, int'(busy0), 0);
      if (c == 11) chk("rst_part", 0, int'(part0), 0);
      if (c == 11) chk("rst_sel", 0, int'(sel0), 0);
      if (c == 13) chk("rst_reload", 0, int'(load0), 1);
      start = (c == 0 || c == 12);
      rst   = (c == 10);
    end
    rst = 1'b0;

    // Back-to-back frames with start held high.
    do_reset();
    for (int c = 0; c < 86; c++) begin
      go_to(c);
      if (c == 38) chk("b2b_load38", 0, int'(load0), 0);
      if (c == 39) chk("b2b_load39", 0, int'(load0), 1);
      if (c == 71) chk("b2b_sel71", 0, int'(sel0), 1);
      if (c == 72) chk("b2b_sel72", 0, int'(sel0), 0);
      if (c == 75) chk("b2b_done75", 0, int'(done0), 1);
`ifdef HUB_FOLD_CTRL_PERF_EN
      if (c == 38) chk("b2b_perf38", 0, int'(perf0), 36);
      if (c == 39) chk("b2b_perf39", 0, int'(perf0), 0);
`endif
      start = (c < 76);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
